// File: rtl/vga_pkg.sv
// Shared display constants and the fill-engine state type.
package vga_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int COLOR_W = 12;
    localparam int ROW_W   = 9;
    localparam int COL_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/vram_fill_addr_gen.sv
// Raster address generator for a rectangle fill.
// load captures the rectangle and starts at its top-left pixel; advance
// steps one pixel in raster order. last marks the bottom-right pixel, and
// the owner stops advancing there, so the row never moves past y1.
module vram_fill_addr_gen
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             advance,
    input  logic [COL_W-1:0] x0,
    input  logic [COL_W-1:0] x1,
    input  logic [ROW_W-1:0] y0,
    input  logic [ROW_W-1:0] y1,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    logic [COL_W-1:0] x0_q;
    logic [COL_W-1:0] x1_q;
    logic [ROW_W-1:0] y1_q;

    // Capture rectangle bounds on load, step the raster cursor on advance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
            row  <= '0;
            col  <= '0;
        end else if (load) begin
            x0_q <= x0;
            x1_q <= x1;
            y1_q <= y1;
            row  <= y0;
            col  <= x0;
        end else if (advance) begin
            if (col == x1_q) begin
                col <= x0_q;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // The cursor sits on the final pixel of the rectangle.
    always_comb begin
        last = (col == x1_q) && (row == y1_q);
    end

endmodule

// File: rtl/vram_fill.sv
// Rectangle fill engine: accepts one fill command at a time and issues one
// VRAM write request per pixel in raster order.
// Handshakes: a command transfers on a cycle with cmd_valid=1 and
// cmd_ready=1; a pixel write completes on a cycle with wen=1 and wr_gnt=1,
// and wr_row/wr_col/wr_data hold steady until that cycle. wr_gnt without wen
// and cmd_valid without cmd_ready are ignored.
module vram_fill #(
    parameter int H_RES   = vga_pkg::H_RES,
    parameter int V_RES   = vga_pkg::V_RES,
    parameter int COLOR_W = vga_pkg::COLOR_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [vga_pkg::COL_W-1:0] cmd_x0,
    input  logic [vga_pkg::COL_W-1:0] cmd_x1,
    input  logic [vga_pkg::ROW_W-1:0] cmd_y0,
    input  logic [vga_pkg::ROW_W-1:0] cmd_y1,
    input  logic [COLOR_W-1:0]        cmd_color,
    output logic                      wen,
    input  logic                      wr_gnt,
    output logic [vga_pkg::ROW_W-1:0] wr_row,
    output logic [vga_pkg::COL_W-1:0] wr_col,
    output logic [COLOR_W-1:0]        wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output vga_pkg::fill_state_t      state_dbg
);

    localparam int COL_W = vga_pkg::COL_W;
    localparam int ROW_W = vga_pkg::ROW_W;
    localparam logic [COL_W-1:0] X_MAX = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(V_RES - 1);

    vga_pkg::fill_state_t state;
    vga_pkg::fill_state_t state_nxt;

    logic [COL_W-1:0]   x1_clamp;
    logic [ROW_W-1:0]   y1_clamp;
    logic               cmd_bad;
    logic               load;
    logic               advance;
    logic               last;
    logic [COLOR_W-1:0] color_q;
    logic               err_q;

    // Clamp the far corner to the screen and decide whether the command is usable.
    always_comb begin
        x1_clamp = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        y1_clamp = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        cmd_bad  = (cmd_x0 > X_MAX) || (cmd_y0 > Y_MAX) ||
                   (cmd_x0 > x1_clamp) || (cmd_y0 > y1_clamp);
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= vga_pkg::ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and outputs; outputs decode from state so reset clears them at once.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wen       = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            vga_pkg::ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && !cmd_bad) begin
                    load      = 1'b1;
                    state_nxt = vga_pkg::ST_FILL;
                end
            end
            vga_pkg::ST_FILL: begin
                wen  = 1'b1;
                busy = 1'b1;
                if (wr_gnt) begin
                    if (last) begin
                        state_nxt = vga_pkg::ST_DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            vga_pkg::ST_DONE: begin
                done      = 1'b1;
                busy      = 1'b1;
                state_nxt = vga_pkg::ST_IDLE;
            end
            default: begin
                state_nxt = vga_pkg::ST_IDLE;
            end
        endcase
    end

    // Colour capture on acceptance; reject pulse one cycle after a bad command.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            color_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= (state == vga_pkg::ST_IDLE) && cmd_valid && cmd_bad;
            if (load) begin
                color_q <= cmd_color;
            end
        end
    end

    vram_fill_addr_gen u_addr_gen (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load),
        .advance (advance),
        .x0      (cmd_x0),
        .x1      (x1_clamp),
        .y0      (cmd_y0),
        .y1      (y1_clamp),
        .row     (wr_row),
        .col     (wr_col),
        .last    (last)
    );

    assign wr_data   = color_q;
    assign err       = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_vram_fill.sv
// Bench for vram_fill. The screen is shrunk to 64x48 so a full-screen fill
// stays short; the clamp and reject cases use the same rules at that size.
module tb_vram_fill;
    import vga_pkg::*;

    localparam int TB_H  = 64;
    localparam int TB_V  = 48;
    localparam int CW    = 12;
    localparam int W     = ROW_W + COL_W + CW;

    logic              clk;
    logic              rstn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [COL_W-1:0]  cmd_x0;
    logic [COL_W-1:0]  cmd_x1;
    logic [ROW_W-1:0]  cmd_y0;
    logic [ROW_W-1:0]  cmd_y1;
    logic [CW-1:0]     cmd_color;
    logic              wen;
    logic              wr_gnt;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [CW-1:0]     wr_data;
    logic              busy;
    logic              done;
    logic              err;
    fill_state_t       state_dbg;

    logic [W-1:0] exp_q[$];
    int n_cmp;
    int n_fail;

    vram_fill #(.H_RES(TB_H), .V_RES(TB_V), .COLOR_W(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_x1    (cmd_x1),
        .cmd_y0    (cmd_y0),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .wen       (wen),
        .wr_gnt    (wr_gnt),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic scramble_cmd();
        cmd_x0    = 10'($urandom);
        cmd_x1    = 10'($urandom);
        cmd_y0    = 9'($urandom);
        cmd_y1    = 9'($urandom);
        cmd_color = 12'($urandom);
    endtask

    // Issue one command and follow it to completion against the model.
    // mode 0: grant always, 1: grant toggles 1/0, 2: random grant.
    task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                           input int color, input int mode);
        int x1c;
        int y1c;
        bit rej;
        int budget;
        bit g;
        bit tog;
        logic [W-1:0] w;
        x1c = (x1 > TB_H - 1) ? TB_H - 1 : x1;
        y1c = (y1 > TB_V - 1) ? TB_V - 1 : y1;
        rej = (x0 >= TB_H) || (y0 >= TB_V) || (x0 > x1c) || (y0 > y1c);
        if (!rej) begin
            for (int r = y0; r <= y1c; r++) begin
                for (int c = x0; c <= x1c; c++) begin
                    exp_q.push_back({ROW_W'(r), COL_W'(c), CW'(color)});
                end
            end
        end
        check("idle_ready", cmd_ready, 1);
        check("idle_wen", wen, 0);
        cmd_valid = 1'b1;
        cmd_x0    = 10'(x0);
        cmd_x1    = 10'(x1);
        cmd_y0    = 9'(y0);
        cmd_y1    = 9'(y1);
        cmd_color = 12'(color);
        wr_gnt    = 1'($urandom_range(0, 1));
        tick();
        cmd_valid = 1'b0;
        scramble_cmd();
        if (rej) begin
            check("rej_err", err, 1);
            check("rej_wen", wen, 0);
            check("rej_busy", busy, 0);
            check("rej_done", done, 0);
            tick();
            check("rej_err_once", err, 0);
            for (int i = 0; i < 3; i++) begin
                wr_gnt = 1'($urandom_range(0, 1));
                check("rej_quiet_wen", wen, 0);
                check("rej_quiet_done", done, 0);
                tick();
            end
        end else begin
            check("acc_err", err, 0);
            budget = 4 * exp_q.size() + 20;
            tog = 1'b1;
            while (exp_q.size() > 0 && budget > 0) begin
                w = exp_q[0];
                check("fill_wen", wen, 1);
                check("fill_busy", busy, 1);
                check("fill_ready", cmd_ready, 0);
                check("fill_done", done, 0);
                check("fill_row", wr_row, w[W-1 -: ROW_W]);
                check("fill_col", wr_col, w[CW+COL_W-1 -: COL_W]);
                check("fill_data", wr_data, w[CW-1:0]);
                case (mode)
                    0:       g = 1'b1;
                    1:       begin g = tog; tog = ~tog; end
                    default: g = 1'($urandom_range(0, 1));
                endcase
                wr_gnt    = g;
                cmd_valid = 1'($urandom_range(0, 1));
                scramble_cmd();
                tick();
                if (g) void'(exp_q.pop_front());
                budget--;
            end
            check("fill_budget_left", 32'(exp_q.size()), 0);
            exp_q.delete();
            cmd_valid = 1'b0;
            wr_gnt    = 1'($urandom_range(0, 1));
            check("done_pulse", done, 1);
            check("done_wen", wen, 0);
            check("done_busy", busy, 1);
            tick();
            check("post_done", done, 0);
            check("post_busy", busy, 0);
            check("post_ready", cmd_ready, 1);
            check("post_err", err, 0);
        end
    endtask

    initial begin
        int rx0;
        int rx1;
        int ry0;
        int ry1;
        n_cmp     = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        wr_gnt    = 1'b0;
        cmd_x0    = '0;
        cmd_x1    = '0;
        cmd_y0    = '0;
        cmd_y1    = '0;
        cmd_color = '0;

        // reset
        repeat (3) tick();
        check("rst_wen", wen, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_row", wr_row, 0);
        check("rst_col", wr_col, 0);
        check("rst_data", wr_data, 0);
        check("rst_state", state_dbg, ST_IDLE);
        rstn = 1'b1;
        tick();
        check("rst_ready", cmd_ready, 1);

        // full screen, constant grant
        run_cmd(0, TB_H - 1, 0, TB_V - 1, 12'hFFF, 0);
        // small rectangle with toggling grant
        run_cmd(10, 12, 20, 21, 12'h0F0, 1);
        // far corner clamped to the screen: 10x10
        run_cmd(TB_H - 10, 1000, TB_V - 10, 511, 12'hA5C, 2);
        // rejects: x0 > x1, y0 off-screen
        run_cmd(5, 3, 0, 0, 12'h111, 0);
        run_cmd(0, 4, TB_V, TB_V + 2, 12'h222, 0);
        // single pixel
        run_cmd(7, 7, 7, 7, 12'h123, 0);
        // bottom-right single pixel
        run_cmd(TB_H - 1, TB_H - 1, TB_V - 1, TB_V - 1, 12'h321, 2);

        // randomized rectangles, some of which are rejected
        for (int k = 0; k < 10; k++) begin
            rx0 = $urandom_range(0, TB_H + 2);
            ry0 = $urandom_range(0, TB_V + 2);
            rx1 = rx0 + $urandom_range(0, 6) - (($urandom_range(0, 5) == 0) ? 8 : 0);
            ry1 = ry0 + $urandom_range(0, 4) - (($urandom_range(0, 5) == 0) ? 6 : 0);
            if (rx1 < 0) rx1 = 0;
            if (ry1 < 0) ry1 = 0;
            run_cmd(rx0, rx1, ry0, ry1, int'($urandom_range(0, 4095)), 2);
        end

        // reset in the middle of a full-screen fill after 50 writes
        cmd_valid = 1'b1;
        cmd_x0    = 10'd0;
        cmd_x1    = 10'(TB_H - 1);
        cmd_y0    = 9'd0;
        cmd_y1    = 9'(TB_V - 1);
        cmd_color = 12'hFFF;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            check("mid_wen", wen, 1);
            check("mid_row", wr_row, 32'(i / TB_H));
            check("mid_col", wr_col, 32'(i % TB_H));
            wr_gnt = 1'b1;
            tick();
        end
        rstn = 1'b0;
        #1;
        check("mid_rst_wen", wen, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_row", wr_row, 0);
        check("mid_rst_col", wr_col, 0);
        check("mid_rst_data", wr_data, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("in_rst_wen", wen, 0);
            check("in_rst_done", done, 0);
        end
        rstn   = 1'b1;
        wr_gnt = 1'b0;
        tick();
        check("after_rst_done", done, 0);
        check("after_rst_wen", wen, 0);
        run_cmd(3, 5, 2, 2, 12'h7E1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_fill.md
VRAM_FILL -- requirements
Module: vram_fill

Interface
REQ-001 Parameter H_RES, default 640, pixel columns in VRAM.
REQ-002 Parameter V_RES, default 480, pixel rows in VRAM.
REQ-003 Parameter COLOR_W, default 12, pixel width (4:4:4 RGB).
REQ-004 clk  input  1  pixel-domain clock; all logic rising-edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  fill command present.
REQ-007 cmd_ready  output  1  engine can accept a command.
REQ-008 cmd_x0, cmd_x1  input  10 each  left/right column, inclusive.
REQ-009 cmd_y0, cmd_y1  input  9 each  top/bottom row, inclusive.
REQ-010 cmd_color  input  COLOR_W  fill colour.
REQ-011 wen  output  1  VRAM write request, active high.
REQ-012 wr_gnt  input  1  VRAM write port granted this cycle.
REQ-013 wr_row  output  9, wr_col  output  10, wr_data  output  COLOR_W  write address/data.
REQ-014 busy  output  1  command in progress; done  output  1  one-cycle completion pulse; err  output  1  one-cycle reject pulse.

Function
REQ-015 States IDLE, FILL, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-016 Command accepted on a cycle with cmd_valid=1 and cmd_ready=1; all cmd_* fields SHALL be registered on acceptance.
REQ-017 Acceptance SHALL clamp x1 to H_RES-1 and y1 to V_RES-1.
REQ-018 Command SHALL be rejected if x0>=H_RES, y0>=V_RES, x0>clamped x1, or y0>clamped y1: err=1 the following cycle, no writes, state stays IDLE, no done.
REQ-019 Valid command: FILL entered the next cycle with wen=1, wr_col=x0, wr_row=y0, wr_data=color (first write request 1 cycle after acceptance).
REQ-020 In FILL, wen SHALL remain 1 and wr_row/wr_col/wr_data SHALL hold stable until wr_gnt=1.
REQ-021 A write completes on a cycle with wen=1 and wr_gnt=1; next address: col+1, or if col==x1 then col=x0, row+1 (raster order).
REQ-022 Completion of the write at (x1,y1) SHALL move to DONE; done=1 for exactly that one cycle, wen=0, then IDLE.
REQ-023 Pixel count per command SHALL equal (x1-x0+1)*(y1-y0+1) after clamping; no duplicate or skipped addresses.
REQ-024 busy SHALL be 1 in FILL and DONE, 0 in IDLE.
REQ-025 wr_gnt while wen=0 SHALL be ignored; cmd_valid outside IDLE SHALL be ignored (no queuing).
REQ-026 Single-pixel command (x0==x1, y0==y1) SHALL produce exactly one write then done.
REQ-027 Address counters SHALL never exceed H_RES-1 / V_RES-1; no wrap beyond y1.

Reset
REQ-028 rstn=0 SHALL immediately force state IDLE, wen=0, done=0, err=0, busy=0, cmd_ready=1 after release, wr_row=0, wr_col=0, wr_data=0.
REQ-029 Reset mid-FILL SHALL abandon the command with no further writes and no done pulse.

Structure
REQ-030 Shared package vga_pkg SHALL hold H_RES, V_RES, COLOR_W, ROW_W=9, COL_W=10, and the fill state enum.
REQ-031 One sub-module, vram_fill_addr_gen, SHALL implement the raster row/column counter with load, advance and last-pixel flag.

Verification
REQ-032 Full screen: x0=0,y0=0,x1=639,y1=479,color=12'hFFF, wr_gnt=1 -> 307200 writes, last at (639,479), done once, busy low next cycle.
REQ-033 Rectangle with stalls: (10,20)-(12,21), color 12'h0F0, wr_gnt toggling 1/0 -> 6 writes in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), outputs stable during wr_gnt=0.
REQ-034 Clamp: (630,470)-(1000,511) -> 10x10=100 writes, last at (639,479).
REQ-035 Reject: x0=5,x1=3 and separately y0=480 -> err pulse one cycle after acceptance, wen never high, done never high.
REQ-036 Single pixel (7,7), color 12'h123 -> one write (7,7,12'h123), done exactly 1 cycle after its grant.
REQ-037 Reset mid-fill: assert rstn=0 after 50 writes of a full-screen fill -> wen=0 asynchronously, no done, next command accepted normally after release.
